// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, checker states and the expected-entry type shared by the ALU checker and its golden model
package alu_pkg;
  localparam int MAX_W = 64;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t OP_ADD  = 4'd0;
  localparam alu_op_t OP_SUB  = 4'd1;
  localparam alu_op_t OP_AND  = 4'd2;
  localparam alu_op_t OP_OR   = 4'd3;
  localparam alu_op_t OP_XOR  = 4'd4;
  localparam alu_op_t OP_SLL  = 4'd5;
  localparam alu_op_t OP_SRL  = 4'd6;
  localparam alu_op_t OP_SRA  = 4'd7;
  localparam alu_op_t OP_SLT  = 4'd8;
  localparam alu_op_t OP_SEQ  = 4'd9;
  localparam alu_op_t OP_SRNE = 4'd10;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  typedef struct packed {
    alu_op_t op;
    logic [MAX_W-1:0] result;
    logic zero;
    logic carry;
    logic overflow;
  } exp_entry_t;
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden ALU producing result, flags and an illegal-opcode indication
module alu_ref_model import alu_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] diff;
  logic [5:0] sh;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign sh = b[5:0];
  // opcode decode of the golden result; unassigned opcodes are flagged illegal
  always_comb begin
    result = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  result = sum[WIDTH-1:0];
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << sh;
      OP_SRL:  result = a >> sh;
      OP_SRA:  result = $unsigned($signed(a) >>> sh);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SEQ:  result = {{(WIDTH-1){1'b0}}, a == b};
      OP_SRNE: result = {{(WIDTH-1){1'b0}}, a != b};
      default: illegal = 1'b1;
    endcase
  end
  assign zero = result == '0;
  assign carry = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? a < b : 1'b0;
  assign overflow = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                    op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
endmodule

// File: rtl/alu_response_checker.sv
// alu_response_checker: snoops ALU issues, compares ALU results after ALU_LAT cycles, counts pass/fail/illegal (ALU_FLAG_CHECK_EN adds flag compare)
module alu_response_checker import alu_pkg::*; #(
  parameter int WIDTH        = 64,
  parameter int ALU_LAT      = 1,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] result,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             overflow_flag,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic             error,
  output logic [3:0]       fail_op,
  output logic [WIDTH-1:0] fail_expected,
  output logic [WIDTH-1:0] fail_actual
);
  state_t st, st_nxt;
  logic [WIDTH-1:0] ref_result;
  logic ref_zero, ref_carry, ref_overflow, ref_illegal;
  logic [ALU_LAT:1] pipe_v, pipe_ill;
  exp_entry_t pipe_e [1:ALU_LAT];
  exp_entry_t head;
  logic [WIDTH-1:0] head_result;
  logic cmp, ill_hit, flags_ok, mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a(operand_A), .b(operand_B), .op(alu_op), .result(ref_result),
    .zero(ref_zero), .carry(ref_carry), .overflow(ref_overflow), .illegal(ref_illegal)
  );

  assign head = pipe_e[ALU_LAT];
  assign head_result = head.result[WIDTH-1:0];
  assign cmp = st == RUN && pipe_v[ALU_LAT] && !pipe_ill[ALU_LAT];
  assign ill_hit = st == RUN && pipe_v[ALU_LAT] && pipe_ill[ALU_LAT];
`ifdef ALU_FLAG_CHECK_EN
  assign flags_ok = {zero_flag, carry_flag, overflow_flag} == {head.zero, head.carry, head.overflow};
`else
  logic unused_flags;
  assign flags_ok = 1'b1;
  assign unused_flags = ^{zero_flag, carry_flag, overflow_flag, head.zero, head.carry, head.overflow};
`endif
  assign mismatch = cmp && (result != head_result || !flags_ok);
  assign state = st;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= IDLE;
    else st <= st_nxt;
  end

  // next state: clear wins, start only leaves IDLE, a mismatch halts when enabled
  always_comb begin
    st_nxt = clear ? IDLE :
             (st == IDLE && start) ? RUN :
             (mismatch && STOP_ON_FAIL != 0) ? HALT : st;
  end

  // expectation pipeline; valids survive only while the checker stays in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
      pipe_ill <= '0;
      for (int i = 1; i <= ALU_LAT; i++) pipe_e[i] <= '0;
    end else begin
      pipe_v <= ((pipe_v << 1) | ALU_LAT'(st == RUN && issue_valid)) & {ALU_LAT{st_nxt == RUN}};
      pipe_ill <= (pipe_ill << 1) | ALU_LAT'(ref_illegal);
      pipe_e[1] <= '{op: alu_op, result: MAX_W'(ref_result), zero: ref_zero, carry: ref_carry, overflow: ref_overflow};
      for (int i = 2; i <= ALU_LAT; i++) pipe_e[i] <= pipe_e[i-1];
    end
  end

  // saturating counters and first-mismatch capture; clear beats a same-cycle compare
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_count <= '0;
      fail_count <= '0;
      illegal_count <= '0;
      error <= 1'b0;
      fail_op <= '0;
      fail_expected <= '0;
      fail_actual <= '0;
    end else if (clear) begin
      pass_count <= '0;
      fail_count <= '0;
      illegal_count <= '0;
      error <= 1'b0;
      fail_op <= '0;
      fail_expected <= '0;
      fail_actual <= '0;
    end else begin
      if (cmp && !mismatch) pass_count <= sat_inc(pass_count);
      if (ill_hit) illegal_count <= sat_inc(illegal_count);
      if (mismatch) begin
        fail_count <= sat_inc(fail_count);
        error <= 1'b1;
        if (!error) begin
          fail_op <= head.op;
          fail_expected <= head_result;
          fail_actual <= result;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_response_checker.sv
// tb_alu_response_checker: scoreboard bench; a delayed ALU response model feeds the checker, a monitor checks every counter change
`timescale 1ns/1ps
module tb_alu_response_checker;
  localparam int LAT = 3;
  localparam int CW = 4;

  logic clk = 0, reset = 0, start = 0, clear = 0, issue_valid = 0;
  logic [63:0] operand_A = 0, operand_B = 0, result;
  logic [3:0] alu_op = 0;
  logic zero_flag, carry_flag, overflow_flag;
  logic [1:0] state;
  logic [CW-1:0] pass_count, fail_count, illegal_count;
  logic error;
  logic [3:0] fail_op;
  logic [63:0] fail_expected, fail_actual;

  logic [63:0] alu_ret = 0;
  logic [2:0] alu_fl = 0;
  logic [63:0] rr [LAT] = '{default: 0};
  logic [2:0] rf [LAT] = '{default: 0};
  int edges = 0, checks = 0, failures = 0;

  typedef struct {int edge_n; logic [CW-1:0] p, f, i;} ev_t;
  ev_t q[$];
  logic [CW-1:0] ep = 0, ef = 0, ei = 0;
  logic [3*CW-1:0] prev = 0;

  alu_response_checker #(.WIDTH(64), .ALU_LAT(LAT), .CNT_W(CW), .STOP_ON_FAIL(1)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .issue_valid(issue_valid),
    .operand_A(operand_A), .operand_B(operand_B), .alu_op(alu_op), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .state(state), .pass_count(pass_count), .fail_count(fail_count), .illegal_count(illegal_count),
    .error(error), .fail_op(fail_op), .fail_expected(fail_expected), .fail_actual(fail_actual)
  );

  always #5 clk = ~clk;

  // ALU stand-in: the value chosen at issue appears on result LAT edges later
  always @(posedge clk) begin
    edges <= edges + 1;
    rr[0] <= alu_ret;
    rf[0] <= alu_fl;
    for (int k = 1; k < LAT; k++) begin
      rr[k] <= rr[k-1];
      rf[k] <= rf[k-1];
    end
  end
  assign result = rr[LAT-1];
  assign {zero_flag, carry_flag, overflow_flag} = rf[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction

  task automatic expect_counts(input int at, input logic [CW-1:0] p, input logic [CW-1:0] f, input logic [CW-1:0] i);
    if ({p, f, i} != {ep, ef, ei}) q.push_back('{at, p, f, i});
    {ep, ef, ei} = {p, f, i};
  endtask

  // kind: 0 ignored/discarded, 1 pass, 2 fail, 3 illegal
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ret, input logic [2:0] fl, input int kind);
    alu_op = op; operand_A = a; operand_B = b; alu_ret = ret; alu_fl = fl; issue_valid = 1;
    if (kind == 1) expect_counts(edges + 1 + LAT, sat(ep), ef, ei);
    else if (kind == 2) expect_counts(edges + 1 + LAT, ep, sat(ef), ei);
    else if (kind == 3) expect_counts(edges + 1 + LAT, ep, ef, sat(ei));
    @(negedge clk);
    issue_valid = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    expect_counts(edges + 1, 0, 0, 0);
    @(negedge clk);
    clear = 0;
  endtask

  // monitor: every counter change must match the next scoreboard event, at its edge
  always @(negedge clk) begin : mon
    ev_t e;
    if ({pass_count, fail_count, illegal_count} !== prev) begin
      if (q.size() == 0) check("unexpected_count_change", {pass_count, fail_count, illegal_count}, prev);
      else begin
        e = q.pop_front();
        check("event_edge", edges, e.edge_n);
        check("ev_pass", pass_count, e.p);
        check("ev_fail", fail_count, e.f);
        check("ev_illegal", illegal_count, e.i);
      end
      prev = {pass_count, fail_count, illegal_count};
    end else if (q.size() != 0 && edges > q[0].edge_n) begin
      check("missing_event_edge", edges, q[0].edge_n);
      void'(q.pop_front());
    end
  end

  initial begin
    wait_cycles(2);
    check("rst_state", state, 0);
    check("rst_counts", {pass_count, fail_count, illegal_count}, 0);
    check("rst_error", error, 0);
    check("rst_fail_capture", {fail_op, fail_expected | fail_actual}, 0);
    reset = 1;
    issue(0, 1, 2, 3, 0, 0);
    wait_cycles(LAT + 2);
    check("idle_ignores_issue", pass_count, 0);
    pulse_start();
    check("state_run", state, 1);
    issue(0, 1, 2, 3, 0, 0);
    #1 reset = 0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_counts", {pass_count, fail_count, illegal_count}, 0);
    @(negedge clk);
    reset = 1;
    wait_cycles(LAT + 3);
    check("post_rst_state", state, 0);

    pulse_start();
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 3'b110, 1);
    issue(1, 7, 5, 2, 3'b000, 1);
    issue(2, 64'hC, 64'hA, 64'h8, 3'b000, 1);
    issue(3, 64'hC, 64'hA, 64'hE, 3'b000, 1);
    issue(4, 64'hC, 64'hA, 64'h6, 3'b000, 1);
    issue(5, 1, 63, 64'h8000_0000_0000_0000, 3'b000, 1);
    issue(6, 64'h8000_0000_0000_0000, 63, 1, 3'b000, 1);
    issue(7, 64'h8000_0000_0000_0000, 63, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1);
    issue(8, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 3'b000, 1);
    issue(9, 5, 5, 1, 3'b000, 1);
    issue(10, 5, 5, 0, 3'b100, 1);
    issue(13, 1, 2, 3, 3'b000, 3);
    issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 3'b001, 1);
    wait_cycles(LAT + 2);
    check("vec_pass_total", pass_count, 12);
    check("vec_illegal_total", illegal_count, 1);
    check("vec_no_error", error, 0);

    do_clear();
    check("clear_state_idle", state, 0);
    pulse_start();
    for (int i = 1; i <= 10; i++) issue(0, i, 1, i + 1, 3'b000, 1);
    wait_cycles(LAT + 2);
    check("b2b_pass_10", pass_count, 10);
    for (int i = 1; i <= 10; i++) issue(0, i, 1, i + 1, 3'b000, 1);
    wait_cycles(LAT + 2);
    check("pass_saturated", pass_count, 15);

    issue(1, 5, 7, 2, 3'b000, 2);
    issue(0, 1, 1, 2, 3'b000, 0);
    wait_cycles(LAT + 2);
    check("halt_state", state, 2);
    check("halt_fail_count", fail_count, 1);
    check("halt_error", error, 1);
    check("halt_fail_op", fail_op, 1);
    check("halt_fail_expected", fail_expected, 64'hFFFF_FFFF_FFFF_FFFE);
    check("halt_fail_actual", fail_actual, 2);
    pulse_start();
    check("start_in_halt", state, 2);
    issue(1, 5, 7, 99, 3'b000, 0);
    wait_cycles(LAT + 2);
    check("halt_frozen_fail", fail_count, 1);

    do_clear();
    check("clear_state", state, 0);
    check("clear_counts", {pass_count, fail_count, illegal_count}, 0);
    check("clear_error", error, 0);
    check("clear_capture", {fail_op, fail_expected | fail_actual}, 0);

    pulse_start();
`ifdef ALU_FLAG_CHECK_EN
    issue(0, 1, 1, 2, 3'b010, 2);
    wait_cycles(LAT + 2);
    check("flag_fail_state", state, 2);
    check("flag_fail_error", error, 1);
    check("flag_fail_actual", fail_actual, 2);
    check("flag_fail_expected", fail_expected, 2);
`else
    issue(0, 1, 1, 2, 3'b010, 1);
    wait_cycles(LAT + 2);
    check("flag_ignored_state", state, 1);
    check("flag_ignored_error", error, 0);
    check("flag_ignored_pass", pass_count, 1);
`endif
    wait_cycles(2);
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_response_checker.md
Name: alu_response_checker

Overview:
- Synthesizable response end of the ALU_64bit operand/opcode interface: snoops each op issued to ALU_64bit, computes the expected result and flags, and compares them with ALU_64bit outputs after a fixed latency.
- Keeps pass, fail and illegal-op counters, and captures the first mismatch.
- Sits beside ALU_64bit in both the self-checking bench and the FPGA build, so checking does not depend on $display inspection.

Parameters:
- WIDTH, 64, operand/result width.
- ALU_LAT, 1, cycles from issue edge to ALU result valid (range 1..4).
- CNT_W, 16, width of each counter.
- STOP_ON_FAIL, 1, 1 = halt on first mismatch; 0 = keep counting.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; IDLE->RUN
- clear  in  1  synchronous clear of counters, pipeline and capture; forces IDLE
- issue_valid  in  1  operand_A/operand_B/alu_op are being presented to the ALU this cycle
- operand_A  in  WIDTH  issued operand A
- operand_B  in  WIDTH  issued operand B
- alu_op  in  4  issued opcode
- result  in  WIDTH  ALU_64bit result
- zero_flag, carry_flag, overflow_flag  in  1 each  ALU_64bit flags
- state  out  2  0 IDLE, 1 RUN, 2 HALT
- pass_count, fail_count, illegal_count  out  CNT_W  saturating counters
- error  out  1  sticky: at least one mismatch
- fail_op  out  4  opcode of first mismatch
- fail_expected, fail_actual  out  WIDTH  result values of first mismatch

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters, error, fail_* = 0; valid pipeline cleared.
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SEQ 9, SRNE 10.
  - Shifts use B[5:0].
  - SLT: signed A<B -> 1, else 0.
  - SEQ: A==B -> 1, else 0.
  - SRNE: A!=B -> 1, else 0.
  - Opcodes 11..15 are illegal.
- Expected flags:
  - zero = (expected result == 0).
  - ADD: carry = bit 64 of the WIDTH+1 sum; overflow = signed overflow.
  - SUB: carry = unsigned borrow (A<B); overflow = signed overflow.
  - All other ops: carry = 0, overflow = 0.
- FSM:
  - IDLE: issue_valid ignored. start -> RUN.
  - RUN: each issue_valid pushes {valid, op, expected, flags} into an ALU_LAT-deep shift pipeline.
  - RUN -> HALT: on a mismatch when STOP_ON_FAIL=1.
  - HALT: compares ignored; in-flight entries discarded; counters frozen. Only clear or reset leaves HALT (-> IDLE).
  - start while in RUN or HALT: no effect.
- Compare: at the edge where a valid entry reaches pipeline stage ALU_LAT, sample result and flags.
  - Match: pass_count+1.
  - Mismatch: fail_count+1 and error=1. If this is the first mismatch, load fail_op/fail_expected/fail_actual.
  - Illegal op: illegal_count+1 only; no compare, no error.
- Counter outputs update at that edge. Reported latency is ALU_LAT cycles from issue to counter change.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Entries already in the pipeline when leaving RUN via clear are dropped. Entries still in flight after RUN->HALT are discarded.
- clear has priority over a simultaneous compare and over start.
- issue_valid on every cycle is supported (one compare per cycle, back-to-back).

Optional Feature:
- ALU_FLAG_CHECK_EN defined: a flag mismatch alone counts as a fail; fail_actual still holds result.
- Not defined: only result is compared; flag inputs are unused and need not be connected.

Decomposition:
- alu_pkg holds:
  - opcode localparams (ADD..SRNE);
  - an alu_op_t 4-bit typedef;
  - state encodings IDLE/RUN/HALT;
  - an expected-entry struct {op, result, zero, carry, overflow}.
- One sub-module, alu_ref_model: purely combinational golden model (operands + opcode -> result + flags + illegal). ALU_64bit's own bench can reuse it.

Test Plan:
- Reset/start: reset low mid-RUN with 1 entry in flight -> all outputs 0, state IDLE, no count change after release.
- Golden ADD, ALU_LAT=1: start; issue A=FFFF_FFFF_FFFF_FFFF, B=1, op 0; ALU returns 0, zero=1, carry=1, overflow=0 -> pass_count=1 one cycle after issue.
- Mismatch with STOP_ON_FAIL=1: issue SUB A=5, B=7 while ALU returns 2 -> fail_count=1, error=1, fail_op=1, fail_expected=FFFF_FFFF_FFFF_FFFE, fail_actual=2, state=HALT. A further issue changes nothing; clear -> IDLE with all counters 0.
- Back-to-back, ALU_LAT=3: 10 consecutive issues with a correct model -> pass_count=10 exactly 3 cycles after the last issue.
- Illegal/edge ops: op 13 -> illegal_count=1; SRA A=8000_0000_0000_0000, B=63 -> expected all-ones, pass; SLT A=-1, B=0 -> expected 1.
- Saturation/flags: CNT_W=4 with 20 passes -> pass_count=15. Correct result with wrong carry -> fail only when ALU_FLAG_CHECK_EN is defined.
